// File: rtl/mux16_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter: source codes, counter width,
// owner state encoding and the saturating burst-count helper.
package mux16_arbiter_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  localparam int   CNT_W = 4;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max_v);
    return (v < max_v) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : max_v;
  endfunction

endpackage

// File: rtl/mux16_arbiter_mux16.sv
// Two-input data steering mux for the shared output datapath; sel = 0 picks a.
module mux16_arbiter_mux16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter sharing one output register between requesters A and B,
// with a bounded burst length for the current owner.
//
// state | meaning
// OWN_A | A owns the datapath; B is granted only when A is idle or A's burst is used up
// OWN_B | B owns the datapath; A is granted only when B is idle or B's burst is used up
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);

  owner_e           r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;

  logic             w_owner_bit;
  logic             w_owner_valid;
  logic             w_other_valid;
  logic             w_load_en;
  logic             w_gnt;
  logic             w_gnt_valid;
  logic             w_fire;
  logic [WIDTH-1:0] w_mux_data;

  assign w_owner_bit   = (r_owner == OWN_B);
  assign w_owner_valid = w_owner_bit ? b_valid : a_valid;
  assign w_other_valid = w_owner_bit ? a_valid : b_valid;
  assign w_load_en     = !r_out_valid || out_ready;

  // Owner keeps the grant until its burst is spent, but only if someone is waiting.
  always_comb begin
    w_gnt = w_owner_bit;
    if (w_owner_valid && ((r_cnt < LP_MAX) || !w_other_valid))
      w_gnt = w_owner_bit;
    else if (w_other_valid)
      w_gnt = !w_owner_bit;
  end

  assign w_gnt_valid = (w_gnt == SRC_B) ? b_valid : a_valid;
  assign w_fire      = w_load_en && w_gnt_valid;

  assign a_ready = reset_n && w_load_en && (w_gnt == SRC_A);
  assign b_ready = reset_n && w_load_en && (w_gnt == SRC_B);

  mux16_arbiter_mux16 #(
    .WIDTH(WIDTH)
  ) u_mux16 (
    .a  (a_data),
    .b  (b_data),
    .sel(w_gnt),
    .y  (w_mux_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_owner     <= OWN_A;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= SRC_A;
    end else if (w_fire) begin
      case (r_owner)
        OWN_A: begin
          if (w_gnt == SRC_B) begin
            r_owner <= OWN_B;
            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_cnt <= sat_inc(r_cnt, LP_MAX);
          end
        end
        OWN_B: begin
          if (w_gnt == SRC_A) begin
            r_owner <= OWN_A;
            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_cnt <= sat_inc(r_cnt, LP_MAX);
          end
        end
        default: begin
          r_owner <= OWN_A;
          r_cnt   <= '0;
        end
      endcase
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_gnt;
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
